seg_serial_adder: RTL and testbench
===================================

Name: seg_serial_adder

Overview:
- Multi-cycle, parametrised ripple-carry adder/subtractor.
- Processes SEG bits per clock across WIDTH/SEG cycles, with one registered carry between segments, trading latency for area.
- Used in datapaths where a full-width ripple carry will not close timing in one cycle.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SEG, 8, bits added per cycle. WIDTH % SEG must be 0; otherwise elaboration fails.
- NSEG (localparam), WIDTH/SEG, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; acts as borrow-in when sub=1.
- sub  input  1  0: a+b+cin; 1: a+~b+(~cin), i.e. a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB; for subtraction, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, seg_idx=0, carry=0.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinationally. in_valid is ignored in RUN and DONE.
- IDLE:
  - On edge with in_valid&&in_ready: latch a into a_r; latch b_eff = sub ? ~b : b; carry = cin ^ sub; seg_idx=0; go to RUN.
- RUN:
  - Each edge: {c, s} = a_r[seg] + b_eff[seg] + carry, an (SEG+1)-bit add.
  - sum[seg_idx*SEG +: SEG] <= s; carry <= c; seg_idx <= seg_idx+1.
  - On the edge processing segment NSEG-1: cout <= c; ovf <= (a_r[MSB]==b_eff[MSB]) && (s[SEG-1]!=a_r[MSB]); out_valid <= 1; go to DONE.
- Latency: out_valid rises exactly NSEG edges after the accept edge. NSEG=1 gives a 1-cycle latency.
- DONE:
  - sum, cout, ovf and out_valid hold stable until the edge where out_ready=1.
  - On that edge: out_valid <= 0, go to IDLE.
  - Minimum spacing between accepts is NSEG+2 cycles; back-to-back overlap is not supported.
- sum is updated segment by segment during RUN and is meaningful only while out_valid=1.
- After handoff, sum, cout and ovf retain the last result until the next operation's segments overwrite them.
- No wrap-around is visible: seg_idx never exceeds NSEG-1 and resets on every accept.
- rst_n low mid-RUN or in DONE: operation is aborted immediately and no out_valid pulse occurs. After release, IDLE with in_ready=1.
- Operands on a/b/cin/sub may change freely after the accept edge; only the latched copies are used.

Test Plan:
All cases use WIDTH=32, SEG=8 unless noted.
- a=0x000000FF, b=0x00000001, cin=0, sub=0 → sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0, cin=1, sub=0 (carry ripples through all 4 segments) → sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → sum=0x80000000, ovf=1, cout=0. Then a=0x80000000, b=0xFFFFFFFF → sum=0x7FFFFFFF, ovf=1, cout=1.
- sub=1, a=5, b=7, cin=0 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then a=7, b=5, cin=1 → sum=0x00000001, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing operands → sum/cout/ovf stable, in_ready=0, nothing accepted. Raise out_ready → out_valid falls next edge, in_ready=1.
- Reset after 2 RUN cycles → out_valid stays 0, all outputs are 0 immediately. After release, a=3, b=4 → sum=7. Repeat the first scenario with SEG=32 (NSEG=1) → 1-cycle latency, same result.

Source files
------------

// File: rtl/seg_serial_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds SEG bits per clock over WIDTH/SEG cycles,
// carrying one registered bit between segments, with valid/ready on both sides.
module seg_serial_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int OFF_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  generate
    if (WIDTH % SEG != 0) begin : g_bad_seg
      $fatal(1, "seg_serial_adder: WIDTH must be a multiple of SEG");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_eff;
  logic             carry;
  logic [IDX_W-1:0] seg_idx;
  logic [OFF_W-1:0] seg_off;
  logic [SEG-1:0]   a_seg;
  logic [SEG-1:0]   b_seg;
  logic [SEG:0]     seg_add;
  logic             last_seg;
  logic             seg_ovf;

  assign in_ready = (state == IDLE);

  // Bit offset of the current segment; always < WIDTH, so it fits a bit-select index.
  assign seg_off  = OFF_W'(seg_idx * SEG);
  assign a_seg    = a_r[seg_off +: SEG];
  assign b_seg    = b_eff[seg_off +: SEG];
  assign seg_add  = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry};
  assign last_seg = (seg_idx == LAST_IDX);

  // Signed overflow: operands agree in sign but the result's sign differs.
  assign seg_ovf  = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (seg_add[SEG-1] != a_r[WIDTH-1]);

  // NOTE: every register here uses non-blocking assignment so all updates in one edge
  // see the pre-edge values (e.g. carry feeds seg_add while carry itself is rewritten).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      seg_idx   <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_eff     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_eff   <= sub ? ~b : b;
            carry   <= cin ^ sub;
            seg_idx <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[seg_off +: SEG] <= seg_add[SEG-1:0];
          carry               <= seg_add[SEG];
          if (last_seg) begin
            cout      <= seg_add[SEG];
            ovf       <= seg_ovf;
            out_valid <= 1'b1;
            seg_idx   <= '0;
            state     <= DONE;
          end else begin
            seg_idx <= seg_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_adder.sv
// Scoreboard bench for seg_serial_adder: a 4-segment instance for the main scenarios and a
// single-segment instance for the 1-cycle latency case. Inputs driven and outputs sampled on negedge.
module tb_seg_serial_adder;

  localparam int NSEG0 = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [31:0] a1, b1, sum1;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb1_q[$];
  int   checks = 0;
  int   errors = 0;

  seg_serial_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seg_serial_adder #(.WIDTH(32), .SEG(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  // Arithmetic reference: full-width integer math, signed range test for overflow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    exp_t   e;
    longint sx, sy, true_s, ux, uy, uc;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    uc = longint'(ci);
    if (!s) begin
      true_s = sx + sy + uc;
      e.cout = ((ux + uy + uc) >= 64'h1_0000_0000);
      e.sum  = x + y + 32'(ci);
    end else begin
      true_s = sx - sy - uc;
      e.cout = (ux >= uy + uc);
      e.sum  = x - y - 32'(ci);
    end
    e.ovf = (true_s > SMAX) || (true_s < SMIN);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=0 cout=0 ovf=0",
               in_ready, out_valid, sum, cout, ovf);
    end
    checks++;
    if ({in_ready1, out_valid1, sum1, cout1, ovf1} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state_nseg1: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=0",
               in_ready1, out_valid1, sum1, cout1, ovf1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  // One operation on the 4-segment instance; 'hold' cycles of backpressure in DONE while
  // in_valid stays high with scrambled operands.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s, input int hold);
    exp_t e;
    int   lat;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept_ready: got in_ready=%b want 1", name, in_ready);
    end
    @(posedge clk);
    sb_q.push_back(model(x, y, ci, s));
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != NSEG0) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, lat, NSEG0);
    end
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: queue empty, want 1 entry", name);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL %s_hold%0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 name, i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (sum !== e.sum) begin
      errors++;
      $display("FAIL %s_sum: got %h want %h", name, sum, e.sum);
    end
    checks++;
    if (cout !== e.cout || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s_flags: got cout=%b ovf=%b want cout=%b ovf=%b", name, cout, ovf, e.cout, e.ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handoff: got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_add_basic();
    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
  endtask

  task automatic test_carry_ripple();
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
  endtask

  task automatic test_overflow();
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("ovf_neg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sub();
    run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op("sub_7_5_b", 32'd7, 32'd5, 1'b1, 1'b1, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_nothing_accepted: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op("b2b", $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_reset_mid_run();
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=0 rdy=1 sum=0 cout=0 ovf=0",
               out_valid, in_ready, sum, cout, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NSEG0 + 1; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_pulse%0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    run_op("after_reset", 32'd3, 32'd4, 1'b0, 1'b0, 0);
  endtask

  task automatic test_nseg1();
    exp_t e;
    a1 = 32'h0000_00FF; b1 = 32'h0000_0001; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL nseg1_ready: got %b want 1", in_ready1);
    end
    @(posedge clk);
    sb1_q.push_back(model(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0));
    @(negedge clk);
    in_valid1 = 1'b0; a1 = $urandom; b1 = $urandom;
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL nseg1_early: got out_valid=%b want 0", out_valid1);
    end
    @(negedge clk);
    checks++;
    if (out_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL nseg1_latency: got out_valid=%b want 1 after one edge", out_valid1);
    end
    e = sb1_q.pop_front();
    checks++;
    if ({sum1, cout1, ovf1} !== {e.sum, e.cout, e.ovf}) begin
      errors++;
      $display("FAIL nseg1_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum1, cout1, ovf1, e.sum, e.cout, e.ovf);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL nseg1_handoff: got vld=%b rdy=%b want vld=0 rdy=1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_ripple();
    test_overflow();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_nseg1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
